// File: rtl/msx_slot_bus_bridge.sv
`timescale 1ns/1ps
// msx_slot_bus_bridge
//   Converts asynchronous Z80 cartridge-slot accesses (memory accesses to this
//   slot and all I/O accesses) into single valid/ready transactions on the
//   internal bus. Read data goes back to the slot through a direction-flagged
//   tri-state driver. The internal interrupt request is forwarded to slot /INT.
//
// Ports
//   clk, reset             internal clock, synchronous active-high reset
//   initial_busy           1 = internal side not ready, new accesses ignored
//   p_slot_*               raw slot pins (strobes active-low, async)
//   p_slot_data            bidirectional data, driven only when p_slot_data_dir=1
//   p_slot_data_dir        1 = bridge drives read data toward the CPU
//   p_slot_int             1 = pull slot /INT low
//   int_n                  internal interrupt request, active-low
//   bus_*                  internal request bus (valid/ready, one-cycle rdata_en)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an armed, unbusy access condition
// REQ     | bus_valid high, request fields held until bus_ready
// WAIT_RD | read accepted, waiting for bus_rdata_en to fill read buffer

module msx_slot_bus_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        initial_busy,
  input  logic        p_slot_reset_n,
  input  logic        p_slot_sltsl_n,
  input  logic        p_slot_mreq_n,
  input  logic        p_slot_ioreq_n,
  input  logic        p_slot_wr_n,
  input  logic        p_slot_rd_n,
  input  logic [15:0] p_slot_address,
  inout  wire  [7:0]  p_slot_data,
  output logic        p_slot_data_dir,
  output logic        p_slot_int,
  input  logic        int_n,
  output logic        bus_memreq,
  output logic        bus_ioreq,
  output logic [15:0] bus_address,
  output logic        bus_write,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_rdata_en
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  logic [1:0]  state;
  logic        armed;
  logic        rd_io;
  logic [7:0]  rd_buf;

  logic [5:0]  strb_meta, strb_sync;
  logic [15:0] addr_meta, addr_sync;
  logic [7:0]  data_meta, data_sync;

  logic slot_reset_n_s, sltsl_n_s, mreq_n_s, ioreq_n_s, wr_n_s, rd_n_s;
  logic rst_int, strobe_act, io_acc, mem_acc, acc, new_acc, start, is_wr, rd_hold;

  // Strobe synchronizers idle high so a reset never looks like an access.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_meta <= '1;
      strb_sync <= '1;
    end else begin
      strb_meta <= {p_slot_reset_n, p_slot_sltsl_n, p_slot_mreq_n,
                    p_slot_ioreq_n, p_slot_wr_n, p_slot_rd_n};
      strb_sync <= strb_meta;
    end
  end

  // Address and data are stable long before the strobes, so they share the
  // same two-stage delay and need no reset.
  always_ff @(posedge clk) begin
    addr_meta <= p_slot_address;
    addr_sync <= addr_meta;
    data_meta <= p_slot_data;
    data_sync <= data_meta;
  end

  assign slot_reset_n_s = strb_sync[5];
  assign sltsl_n_s      = strb_sync[4];
  assign mreq_n_s       = strb_sync[3];
  assign ioreq_n_s      = strb_sync[2];
  assign wr_n_s         = strb_sync[1];
  assign rd_n_s         = strb_sync[0];

  assign rst_int    = reset | ~slot_reset_n_s;
  assign strobe_act = ~wr_n_s | ~rd_n_s;
  assign io_acc     = ~ioreq_n_s & strobe_act;
  assign mem_acc    = ~mreq_n_s & ~sltsl_n_s & strobe_act;
  assign acc        = io_acc | mem_acc;
  assign is_wr      = ~wr_n_s;
  // new_acc also fires while busy so that ignored accesses consume the arm
  // and a busy-time read still gets its 0xFF response.
  assign new_acc    = (state == ST_IDLE) & armed & acc;
  assign start      = new_acc & ~initial_busy;
  // Read drive holds only while /RD and the strobe that selected this read stay low.
  assign rd_hold    = ~rd_n_s & (rd_io ? ~ioreq_n_s : (~mreq_n_s & ~sltsl_n_s));

  always_ff @(posedge clk) begin
    if (rst_int) begin
      state           <= ST_IDLE;
      armed           <= 1'b1;
      bus_valid       <= 1'b0;
      bus_memreq      <= 1'b0;
      bus_ioreq       <= 1'b0;
      bus_write       <= 1'b0;
      bus_address     <= 16'h0000;
      bus_wdata       <= 8'h00;
      p_slot_data_dir <= 1'b0;
      rd_io           <= 1'b0;
      rd_buf          <= 8'hFF;
    end else begin
      if (!acc)
        armed <= 1'b1;
      else if (state == ST_IDLE)
        armed <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ;
            bus_valid   <= 1'b1;
            bus_ioreq   <= io_acc;
            bus_memreq  <= ~io_acc;
            bus_write   <= is_wr;
            bus_address <= addr_sync;
            if (is_wr)
              bus_wdata <= data_sync;
          end
        end
        ST_REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= bus_write ? ST_IDLE : ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (bus_rdata_en) begin
            rd_buf <= bus_rdata;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (new_acc & ~is_wr) begin
        p_slot_data_dir <= 1'b1;
        rd_io           <= io_acc;
        rd_buf          <= 8'hFF;
      end else if (p_slot_data_dir & ~rd_hold) begin
        p_slot_data_dir <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_int)
      p_slot_int <= 1'b0;
    else
      p_slot_int <= ~int_n;
  end

  assign p_slot_data = p_slot_data_dir ? rd_buf : 8'hzz;

endmodule

// File: tb/tb_msx_slot_bus_bridge.sv
`timescale 1ns/1ps
// Testbench for msx_slot_bus_bridge: Z80-style slot accesses with a responding
// internal bus target and an access-level expectation model.
module tb_msx_slot_bus_bridge;

  logic        clk = 1'b0;
  logic        reset, initial_busy, p_slot_reset_n;
  logic        p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n, p_slot_wr_n, p_slot_rd_n;
  logic [15:0] p_slot_address;
  wire  [7:0]  p_slot_data;
  logic        p_slot_data_dir, p_slot_int, int_n;
  logic        bus_memreq, bus_ioreq, bus_write, bus_valid, bus_ready, bus_rdata_en;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata, bus_rdata;

  logic        cpu_drive;
  logic [7:0]  cpu_data;
  assign p_slot_data = cpu_drive ? cpu_data : 8'hzz;

  int checks = 0;
  int errors = 0;

  // target configuration
  logic        target_en;
  int          ready_delay, rdata_delay;
  logic [7:0]  rdata_value;
  logic        target_rd;

  // monitor state
  int          rises;
  logic        prev_valid;
  logic [26:0] cap;

  logic [15:0] io_addr [6] = '{16'h0098, 16'h0089, 16'h0078, 16'h0067, 16'h0056, 16'h0045};
  logic [7:0]  io_data [6] = '{8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67};

  always #6 clk = ~clk;

  msx_slot_bus_bridge dut (
    .clk(clk), .reset(reset), .initial_busy(initial_busy), .p_slot_reset_n(p_slot_reset_n),
    .p_slot_sltsl_n(p_slot_sltsl_n), .p_slot_mreq_n(p_slot_mreq_n), .p_slot_ioreq_n(p_slot_ioreq_n),
    .p_slot_wr_n(p_slot_wr_n), .p_slot_rd_n(p_slot_rd_n), .p_slot_address(p_slot_address),
    .p_slot_data(p_slot_data), .p_slot_data_dir(p_slot_data_dir), .p_slot_int(p_slot_int),
    .int_n(int_n), .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq), .bus_address(bus_address),
    .bus_write(bus_write), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Internal bus target: ready after ready_delay cycles, then read data.
  initial begin
    bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (target_en && bus_valid) begin
        target_rd = !bus_write;
        repeat (ready_delay) @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        if (target_rd) begin
          repeat (rdata_delay) @(negedge clk);
          bus_rdata = rdata_value; bus_rdata_en = 1'b1;
          @(negedge clk);
          bus_rdata = 8'h00; bus_rdata_en = 1'b0;
        end
      end
    end
  end

  // Bus monitor: counts requests, checks field stability and the drop after handshake.
  initial begin
    prev_valid = 1'b0;
    rises = 0;
    cap = '0;
    forever begin
      @(posedge clk); #2;
      if (prev_valid && bus_ready)
        check("valid_drop_after_ready", bus_valid, 0);
      if (bus_valid && !prev_valid) begin
        rises++;
        cap = {bus_ioreq, bus_memreq, bus_write, bus_address, bus_wdata};
        check("onehot_type", bus_ioreq ^ bus_memreq, 1);
      end else if (bus_valid && prev_valid) begin
        check("req_stable", {bus_ioreq, bus_memreq, bus_write, bus_address, bus_wdata}, cap);
      end
      prev_valid = bus_valid;
    end
  end

  // One CPU access. Offsets are ns from the T2 rising edge; strobes release together.
  task automatic z80_access(input bit is_io, input bit is_wr, input logic [15:0] addr,
                            input logic [7:0] wdata, input bit sltsl_n, input int t_sel,
                            input int t_strb, input bit busy);
    bit         exp_txn, exp_dir;
    logic [7:0] exp_rd;
    int         t_last;
    exp_txn = !busy && (is_io || !sltsl_n);
    exp_dir = is_io || !sltsl_n;
    exp_rd  = exp_txn ? rdata_value : 8'hFF;
    initial_busy = busy;
    rises = 0;
    p_slot_address = addr;
    if (is_wr) begin cpu_data = wdata; cpu_drive = 1'b1; end
    if (t_sel <= t_strb) begin
      #(t_sel);
      if (is_io) p_slot_ioreq_n = 1'b0; else begin p_slot_mreq_n = 1'b0; p_slot_sltsl_n = sltsl_n; end
      #(t_strb - t_sel);
      if (is_wr) p_slot_wr_n = 1'b0; else p_slot_rd_n = 1'b0;
      t_last = t_strb;
    end else begin
      #(t_strb);
      if (is_wr) p_slot_wr_n = 1'b0; else p_slot_rd_n = 1'b0;
      #(t_sel - t_strb);
      if (is_io) p_slot_ioreq_n = 1'b0; else begin p_slot_mreq_n = 1'b0; p_slot_sltsl_n = sltsl_n; end
      t_last = t_sel;
    end
    #(700 - t_last);
    if (!is_wr) begin
      check("rd_dir_before_t3", p_slot_data_dir, exp_dir);
      if (exp_dir) check("rd_data_before_t3", p_slot_data, exp_rd);
    end
    p_slot_ioreq_n = 1'b1; p_slot_mreq_n = 1'b1; p_slot_sltsl_n = 1'b1;
    p_slot_wr_n = 1'b1; p_slot_rd_n = 1'b1;
    cpu_drive = 1'b0;
    if (!is_wr) begin
      repeat (3) @(posedge clk); #1;
      check("rd_dir_release", p_slot_data_dir, 0);
    end
    #300;
    initial_busy = 1'b0;
    check("txn_count", rises, exp_txn ? 1 : 0);
    check("valid_idle_between", bus_valid, 0);
    if (exp_txn) begin
      check("txn_ioreq", cap[26], is_io);
      check("txn_memreq", cap[25], !is_io);
      check("txn_write", cap[24], is_wr);
      check("txn_address", cap[23:8], addr);
      if (is_wr) check("txn_wdata", cap[7:0], wdata);
    end
  endtask

  initial begin
    bit         found;
    bit         r_io, r_wr, r_sl, r_busy;
    int         base, t_a, t_b;
    reset = 1'b1; p_slot_reset_n = 1'b1; initial_busy = 1'b0; int_n = 1'b1;
    p_slot_sltsl_n = 1'b1; p_slot_mreq_n = 1'b1; p_slot_ioreq_n = 1'b1;
    p_slot_wr_n = 1'b1; p_slot_rd_n = 1'b1; p_slot_address = 16'h0000;
    cpu_drive = 1'b0; cpu_data = 8'h00;
    target_en = 1'b1; ready_delay = 3; rdata_delay = 1; rdata_value = 8'h00;

    repeat (5) @(posedge clk); #1;
    check("rst_valid", bus_valid, 0);
    check("rst_memreq", bus_memreq, 0);
    check("rst_ioreq", bus_ioreq, 0);
    check("rst_write", bus_write, 0);
    check("rst_address", bus_address, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_dir", p_slot_data_dir, 0);
    check("rst_int", p_slot_int, 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);

    // I/O writes, /WR before /IORQ and then /IORQ after /WR at later times
    for (int i = 0; i < 6; i++) z80_access(1, 1, io_addr[i], io_data[i], 1, 135, 125, 0);
    for (int i = 0; i < 6; i++) z80_access(1, 1, io_addr[i], io_data[i], 1, 175, 165, 0);

    // memory read in slot
    rdata_value = 8'hA5;
    z80_access(0, 0, 16'h4000, 8'h00, 0, 120, 125, 0);
    // memory write to another slot: ignored
    z80_access(0, 1, 16'h4000, 8'h99, 1, 120, 165, 0);
    // busy I/O write ignored, next one serviced
    z80_access(1, 1, 16'h0034, 8'h77, 1, 135, 125, 1);
    z80_access(1, 1, 16'h0035, 8'h78, 1, 135, 125, 0);
    // busy read returns 0xFF without a request
    z80_access(1, 0, 16'h0099, 8'h00, 1, 135, 125, 1);

    // randomized accesses
    for (int n = 0; n < 28; n++) begin
      r_io   = $urandom_range(0, 1);
      r_wr   = $urandom_range(0, 1);
      r_sl   = r_io ? 1'b1 : ($urandom_range(0, 3) == 0);
      r_busy = ($urandom_range(0, 4) == 0);
      ready_delay = $urandom_range(0, 3);
      rdata_delay = $urandom_range(0, 3);
      rdata_value = 8'($urandom);
      base = $urandom_range(100, 170);
      if ($urandom_range(0, 1) == 1) begin t_a = base; t_b = base + $urandom_range(40, 50); end
      else begin t_b = base; t_a = base + $urandom_range(40, 50); end
      z80_access(r_io, r_wr, 16'($urandom), 8'($urandom), r_sl, t_a, t_b, r_busy);
    end

    // interrupt forwarding
    @(negedge clk); int_n = 1'b0;
    @(posedge clk); #1;
    check("int_assert", p_slot_int, 1);
    @(negedge clk); int_n = 1'b1;
    @(posedge clk); #1;
    check("int_release", p_slot_int, 0);

    // reset in the middle of a pending request
    target_en = 1'b0;
    p_slot_address = 16'h00A8; cpu_data = 8'h5C; cpu_drive = 1'b1;
    p_slot_ioreq_n = 1'b0; p_slot_wr_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus_valid) begin found = 1'b1; break; end
    end
    check("midreq_valid_seen", found, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreq_reset_valid", bus_valid, 0);
    check("midreq_reset_ioreq", bus_ioreq, 0);
    p_slot_ioreq_n = 1'b1; p_slot_wr_n = 1'b1; cpu_drive = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);

    // slot /RESET in the middle of a pending request
    p_slot_ioreq_n = 1'b0; p_slot_rd_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus_valid) begin found = 1'b1; break; end
    end
    check("slotrst_valid_seen", found, 1);
    @(negedge clk); p_slot_reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("slotrst_valid", bus_valid, 0);
    check("slotrst_dir", p_slot_data_dir, 0);
    p_slot_ioreq_n = 1'b1; p_slot_rd_n = 1'b1;
    repeat (4) @(posedge clk);
    p_slot_reset_n = 1'b1;
    repeat (6) @(posedge clk);

    // bridge resumes normal service afterwards
    target_en = 1'b1; ready_delay = 1;
    z80_access(1, 1, 16'h0011, 8'hC3, 1, 135, 125, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
